morse_decoder: RTL and testbench

//  Receive-side counterpart of the Morse encoder. Times a single key input in clock cycles and classifies

---
 rtl/morse_decoder_pkg.sv | 119 +++++++++++
 rtl/morse_rom.sv | 23 ++
 rtl/morse_decoder.sv | 155 +++++++++++++++
 tb/tb_morse_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/morse_decoder_pkg.sv
// Shared Morse definitions: FSM states, symbol values, character codes and the
// code -> (length, symbol bits) table that the encoder and decoder both use.
package morse_decoder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StSpace,
        StEmit
    } state_e;

    localparam logic SYM_PONTO = 1'b0;
    localparam logic SYM_TRACO = 1'b1;

    localparam int unsigned MAX_SYMS  = 5;
    localparam int unsigned NUM_CODES = 36;

    localparam logic [5:0] CODE_0 = 6'd0;
    localparam logic [5:0] CODE_1 = 6'd1;
    localparam logic [5:0] CODE_2 = 6'd2;
    localparam logic [5:0] CODE_3 = 6'd3;
    localparam logic [5:0] CODE_4 = 6'd4;
    localparam logic [5:0] CODE_5 = 6'd5;
    localparam logic [5:0] CODE_6 = 6'd6;
    localparam logic [5:0] CODE_7 = 6'd7;
    localparam logic [5:0] CODE_8 = 6'd8;
    localparam logic [5:0] CODE_9 = 6'd9;
    localparam logic [5:0] CODE_A = 6'd10;
    localparam logic [5:0] CODE_B = 6'd11;
    localparam logic [5:0] CODE_C = 6'd12;
    localparam logic [5:0] CODE_D = 6'd13;
    localparam logic [5:0] CODE_E = 6'd14;
    localparam logic [5:0] CODE_F = 6'd15;
    localparam logic [5:0] CODE_G = 6'd16;
    localparam logic [5:0] CODE_H = 6'd17;
    localparam logic [5:0] CODE_I = 6'd18;
    localparam logic [5:0] CODE_J = 6'd19;
    localparam logic [5:0] CODE_K = 6'd20;
    localparam logic [5:0] CODE_L = 6'd21;
    localparam logic [5:0] CODE_M = 6'd22;
    localparam logic [5:0] CODE_N = 6'd23;
    localparam logic [5:0] CODE_O = 6'd24;
    localparam logic [5:0] CODE_P = 6'd25;
    localparam logic [5:0] CODE_Q = 6'd26;
    localparam logic [5:0] CODE_R = 6'd27;
    localparam logic [5:0] CODE_S = 6'd28;
    localparam logic [5:0] CODE_T = 6'd29;
    localparam logic [5:0] CODE_U = 6'd30;
    localparam logic [5:0] CODE_V = 6'd31;
    localparam logic [5:0] CODE_W = 6'd32;
    localparam logic [5:0] CODE_X = 6'd33;
    localparam logic [5:0] CODE_Y = 6'd34;
    localparam logic [5:0] CODE_Z = 6'd35;

    // Symbol bits are left-aligned: first symbol in bit 4, 1 = traco.
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] bits;
    } pattern_t;

    function automatic pattern_t char_pattern(input logic [5:0] code);
        pattern_t p;
        p = '0;
        case (code)
            CODE_0: p = {3'd5, 5'b11111};
            CODE_1: p = {3'd5, 5'b01111};
            CODE_2: p = {3'd5, 5'b00111};
            CODE_3: p = {3'd5, 5'b00011};
            CODE_4: p = {3'd5, 5'b00001};
            CODE_5: p = {3'd5, 5'b00000};
            CODE_6: p = {3'd5, 5'b10000};
            CODE_7: p = {3'd5, 5'b11000};
            CODE_8: p = {3'd5, 5'b11100};
            CODE_9: p = {3'd5, 5'b11110};
            CODE_A: p = {3'd2, 5'b01000};
            CODE_B: p = {3'd4, 5'b10000};
            CODE_C: p = {3'd4, 5'b10100};
            CODE_D: p = {3'd3, 5'b10000};
            CODE_E: p = {3'd1, 5'b00000};
            CODE_F: p = {3'd4, 5'b00100};
            CODE_G: p = {3'd3, 5'b11000};
            CODE_H: p = {3'd4, 5'b00000};
            CODE_I: p = {3'd2, 5'b00000};
            CODE_J: p = {3'd4, 5'b01110};
            CODE_K: p = {3'd3, 5'b10100};
            CODE_L: p = {3'd4, 5'b01000};
            CODE_M: p = {3'd2, 5'b11000};
            CODE_N: p = {3'd2, 5'b10000};
            CODE_O: p = {3'd3, 5'b11100};
            CODE_P: p = {3'd4, 5'b01100};
            CODE_Q: p = {3'd4, 5'b11010};
            CODE_R: p = {3'd3, 5'b01000};
            CODE_S: p = {3'd3, 5'b00000};
            CODE_T: p = {3'd1, 5'b10000};
            CODE_U: p = {3'd3, 5'b00100};
            CODE_V: p = {3'd4, 5'b00010};
            CODE_W: p = {3'd3, 5'b01100};
            CODE_X: p = {3'd4, 5'b10010};
            CODE_Y: p = {3'd4, 5'b10110};
            CODE_Z: p = {3'd4, 5'b11000};
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [4:0] len_mask(input logic [2:0] len);
        logic [4:0] m;
        case (len)
            3'd1:    m = 5'b10000;
            3'd2:    m = 5'b11000;
            3'd3:    m = 5'b11100;
            3'd4:    m = 5'b11110;
            3'd5:    m = 5'b11111;
            default: m = 5'b00000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/morse_rom.sv
// Inverse Morse table: (symbol bits, length) -> character code, with a hit flag
// for patterns that have no entry.
module morse_rom
    import morse_decoder_pkg::*;
(
    input  logic [4:0] morse_i,
    input  logic [2:0] len_i,
    output logic [5:0] num_o,
    output logic       hit_o
);

    always_comb begin
        num_o = '0;
        hit_o = 1'b0;
        for (int unsigned c = 0; c < NUM_CODES; c++) begin
            if (char_pattern(6'(c)) == {len_i, morse_i}) begin
                num_o = 6'(c);
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: times key marks/spaces, collects dot/dash symbols and emits
// the decoded character code after a long silence.
module morse_decoder
    import morse_decoder_pkg::*;
#(
    parameter int unsigned DOT_MAX  = 3,
    parameter int unsigned CHAR_GAP = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    output logic [5:0] num,
    output logic       ready,
    output logic       err,
    output logic [4:0] morse,
    output logic [4:0] display
);

    localparam logic [CNT_W-1:0] DotMaxCnt = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] GapCnt    = CNT_W'(CHAR_GAP);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       len_q, len_d;
    logic [4:0]       buf_q, buf_d;
    logic             ovf_q, ovf_d;
    logic [5:0]       num_q, num_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [4:0]       morse_q, morse_d;
    logic [4:0]       display_q, display_d;

    logic [5:0] rom_num;
    logic       rom_hit;
    logic       sym;

    morse_rom u_rom (
        .morse_i (buf_q),
        .len_i   (len_q),
        .num_o   (rom_num),
        .hit_o   (rom_hit)
    );

    // Saturated counter still compares above DOT_MAX, so it stays a dash.
    assign sym = (cnt_q > DotMaxCnt) ? SYM_TRACO : SYM_PONTO;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        buf_d     = buf_q;
        ovf_d     = ovf_q;
        num_d     = num_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        morse_d   = morse_q;
        display_d = display_q;

        unique case (state_q)
            StIdle: begin
                if (key) begin
                    state_d = StMark;
                    cnt_d   = CntOne;
                end
            end
            StMark: begin
                if (key) begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntOne;
                    end
                end else begin
                    if (len_q < 3'(MAX_SYMS)) begin
                        buf_d[3'd4 - len_q] = sym;
                        len_d               = len_q + 3'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    state_d = StSpace;
                    cnt_d   = CntOne;
                end
            end
            StSpace: begin
                if (key) begin
                    state_d = StMark;
                    cnt_d   = CntOne;
                end else if (cnt_q < GapCnt) begin
                    cnt_d = cnt_q + CntOne;
                end else begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (rom_hit && !ovf_q) begin
                    ready_d   = 1'b1;
                    num_d     = rom_num;
                    morse_d   = buf_q;
                    display_d = len_mask(len_q);
                end else begin
                    err_d = 1'b1;
                end
                buf_d = '0;
                len_d = '0;
                ovf_d = 1'b0;
                // A key already down here is the first mark cycle of the next character.
                if (key) begin
                    state_d = StMark;
                    cnt_d   = CntOne;
                end else begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_q     <= '0;
            buf_q     <= '0;
            ovf_q     <= 1'b0;
            num_q     <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            morse_q   <= '0;
            display_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            buf_q     <= buf_d;
            ovf_q     <= ovf_d;
            num_q     <= num_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            morse_q   <= morse_d;
            display_q <= display_d;
        end
    end

    assign num     = num_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign morse   = morse_q;
    assign display = display_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: the driver predicts each ready/err pulse
// from a string-based Morse table; a negedge monitor pops and compares.
module tb_morse_decoder;

    localparam int DOT_MAX  = 3;
    localparam int CHAR_GAP = 8;
    localparam int CNT_W    = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key = 1'b0;
    logic [5:0] num;
    logic       ready;
    logic       err;
    logic [4:0] morse;
    logic [4:0] display;

    morse_decoder #(
        .DOT_MAX  (DOT_MAX),
        .CHAR_GAP (CHAR_GAP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key     (key),
        .num     (num),
        .ready   (ready),
        .err     (err),
        .morse   (morse),
        .display (display)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int is_ready;
        int num;
        int morse;
        int disp;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    string tbl[36] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....",
                       "--...", "---..", "----.",
                       ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    int mk[$];
    int fixed_gap = 0;
    int last_num = 0;
    int last_morse = 0;
    int last_disp = 0;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int lookup(input string p);
        for (int c = 0; c < 36; c++) begin
            if (tbl[c] == p) return c;
        end
        return -1;
    endfunction

    task automatic tick_key(input logic v);
        @(posedge clk);
        #1;
        key = v;
    endtask

    // Sends the marks in mk, predicts the outcome, then holds key low for silence cycles.
    task automatic send_char(input int silence);
        string pat;
        exp_t  e;
        int    code;
        int    g;
        int    bits;
        int    mask;
        pat = "";
        foreach (mk[i]) begin
            if (mk[i] > DOT_MAX) pat = {pat, "-"};
            else pat = {pat, "."};
        end
        foreach (mk[i]) begin
            repeat (mk[i]) tick_key(1'b1);
            if (i != mk.size() - 1) begin
                g = (fixed_gap > 0) ? fixed_gap : int'($urandom_range(1, 7));
                repeat (g) tick_key(1'b0);
            end
        end
        code = lookup(pat);
        e.cyc = cyc + 1 + CHAR_GAP + 2;
        if (code >= 0) begin
            bits = 0;
            mask = 0;
            for (int i = 0; i < pat.len(); i++) begin
                mask = mask | (1 << (4 - i));
                if (pat[i] == "-") bits = bits | (1 << (4 - i));
            end
            last_num   = code;
            last_morse = bits;
            last_disp  = mask;
            e.is_ready = 1;
        end else begin
            e.is_ready = 0;
        end
        e.num   = last_num;
        e.morse = last_morse;
        e.disp  = last_disp;
        exp_q.push_back(e);
        repeat (silence) tick_key(1'b0);
    endtask

    always @(negedge clk) begin
        check("ready_err_exclusive", int'(ready & err), 0);
        if (ready || err) begin
            check("pulse_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("pulse_kind_ready", int'(ready), mon_e.is_ready);
                check("pulse_cycle", cyc, mon_e.cyc);
                check("num", int'(num), mon_e.num);
                check("morse", int'(morse), mon_e.morse);
                check("display", int'(display), mon_e.disp);
            end
        end
    end

    initial begin
        int c;
        int n;
        string p;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("reset_num", int'(num), 0);
        check("reset_ready", int'(ready), 0);
        check("reset_err", int'(err), 0);
        check("reset_morse", int'(morse), 0);
        check("reset_display", int'(display), 0);
        reset = 1'b0;
        repeat (2) tick_key(1'b0);

        // A: dot, gap, dash
        fixed_gap = 2;
        mk = '{2, 6};
        send_char(10);
        // 0: five dashes, then E as a single 1-cycle mark
        mk = '{6, 6, 6, 6, 6};
        send_char(12);
        mk = '{1};
        send_char(12);
        // Overflow and a pattern with no entry
        mk = '{2, 2, 2, 2, 2, 2};
        send_char(12);
        mk = '{2, 2, 6, 6};
        send_char(12);

        // Reset mid-character: no pulse, outputs cleared
        repeat (2) tick_key(1'b1);
        repeat (2) tick_key(1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) tick_key(1'b0);
        check("rst_mid_num", int'(num), 0);
        check("rst_mid_morse", int'(morse), 0);
        check("rst_mid_display", int'(display), 0);
        check("rst_mid_ready", int'(ready), 0);
        check("rst_mid_err", int'(err), 0);
        last_num   = 0;
        last_morse = 0;
        last_disp  = 0;

        // T then E, with E's key rising in the emit cycle of T
        mk = '{6};
        send_char(CHAR_GAP + 1);
        mk = '{2};
        send_char(12);
        // DOT_MAX boundary
        mk = '{3};
        send_char(12);
        mk = '{4};
        send_char(12);
        // Saturating dash
        mk = '{300};
        send_char(12);

        fixed_gap = 0;
        for (int k = 0; k < 40; k++) begin
            mk = {};
            if ($urandom_range(0, 3) != 0) begin
                c = int'($urandom_range(0, 35));
                p = tbl[c];
                for (int i = 0; i < p.len(); i++) begin
                    if (p[i] == "-") mk.push_back(int'($urandom_range(DOT_MAX + 1, 10)));
                    else mk.push_back(int'($urandom_range(1, DOT_MAX)));
                end
            end else begin
                n = int'($urandom_range(1, 6));
                for (int i = 0; i < n; i++) begin
                    mk.push_back(int'($urandom_range(1, 9)));
                end
            end
            send_char(int'($urandom_range(CHAR_GAP + 1, CHAR_GAP + 6)));
        end

        repeat (20) tick_key(1'b0);
        check("all_pulses_seen", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
